// File: rtl/acl_pkg.sv
// Shared definitions for the ACL header parser: Ethernet/IPv4 byte offsets,
// protocol constants, the lookup key layout and the parser state encoding.
package acl_pkg;

    // Offsets of an untagged frame; a VLAN tag pushes everything from 12 by VLAN_SHIFT.
    localparam int OFF_ETYPE    = 12;
    localparam int OFF_VIHL     = 14;
    localparam int OFF_PROTO    = 23;
    localparam int OFF_SRC_IP   = 26;
    localparam int OFF_DST_IP   = 30;
    localparam int OFF_SRC_PORT = 34;
    localparam int OFF_DST_PORT = 36;
    localparam int OFF_HDR_END  = OFF_DST_PORT + 1;
    localparam int VLAN_SHIFT   = 4;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
    localparam logic [7:0]  PROTO_TCP      = 8'd6;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [7:0]  proto;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic        ipv4;
        logic        l4_valid;
        logic        runt;
    } acl_key_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } acl_state_e;

    function automatic logic is_l4_proto(input logic [7:0] proto);
        return (proto == PROTO_TCP) || (proto == PROTO_UDP);
    endfunction

endpackage

// File: rtl/acl_key_slot.sv
// Single-entry key register between the parser and the ACL match engine.
// A key transfers on any cycle where valid_o and ready_i are both 1; a load on that same cycle replaces it and keeps valid_o high.
module acl_key_slot
    import acl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load_i,
    input  acl_key_t key_i,
    input  logic     ready_i,
    output logic     valid_o,
    output acl_key_t key_o
);

    logic     valid_q, valid_d;
    acl_key_t key_q, key_d;

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        if (load_i) begin
            valid_d = 1'b1;
            key_d   = key_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            key_q   <= '0;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
        end
    end

    assign valid_o = valid_q;
    assign key_o   = key_q;

endmodule

// File: rtl/acl_hdr_parser.sv
// Forwards FIFO bytes to AXI-stream unchanged while snooping the Ethernet/IPv4
// header into one 5-tuple key per packet. ACL_PARSE_VLAN_EN enables 802.1Q tag skipping.
module acl_hdr_parser
    import acl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_last,
    input  logic                  i_fifo_empty,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_txd_tdata,
    output logic                  o_txd_tvalid,
    output logic                  o_txd_tlast,
    input  logic                  i_txd_tready,
    output logic                  o_key_valid,
    input  logic                  i_key_ready,
    output logic [31:0]           o_key_src_ip,
    output logic [31:0]           o_key_dst_ip,
    output logic [7:0]            o_key_proto,
    output logic [15:0]           o_key_src_port,
    output logic [15:0]           o_key_dst_port,
    output logic                  o_key_ipv4,
    output logic                  o_key_l4_valid,
    output logic                  o_key_runt,
    output acl_state_e            o_dbg_state
);

    acl_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, off;
    logic [15:0]          etype_q, etype_d;
    logic [7:0]           vihl_q, vihl_d;
    logic [7:0]           proto_q, proto_d;
    logic [31:0]          sip_q, sip_d;
    logic [31:0]          dip_q, dip_d;
    logic [15:0]          sport_q, sport_d;
    logic [15:0]          dport_q, dport_d;
    logic                 vlan_q, vlan_d;
    logic [7:0]           byte_in;
    logic                 stall, pop, key_load, key_runt, ipv4, l4_valid;
    acl_key_t             key_new, key_cur;

    assign byte_in = i_fifo_data[7:0];

    // A new packet may not start while the previous key is still waiting.
    assign stall        = (state_q == ST_IDLE) && o_key_valid && !i_key_ready;
    assign o_txd_tvalid = rst && !i_fifo_empty && !stall;
    assign o_rd_valid   = o_txd_tvalid && i_txd_tready;
    assign o_txd_tdata  = rst ? i_fifo_data : '0;
    assign o_txd_tlast  = rst && i_fifo_last;
    assign pop          = o_rd_valid;

    assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign off     = (vlan_q && (cnt_q >= CNT_WIDTH'(OFF_VIHL)))
                   ? cnt_q - CNT_WIDTH'(VLAN_SHIFT) : cnt_q;

    always_comb begin
        etype_d = etype_q;
        vihl_d  = vihl_q;
        proto_d = proto_q;
        sip_d   = sip_q;
        dip_d   = dip_q;
        sport_d = sport_q;
        dport_d = dport_q;
        vlan_d  = vlan_q;
        if (pop && (state_q == ST_IDLE)) begin
            etype_d = '0;
            vihl_d  = '0;
            proto_d = '0;
            sip_d   = '0;
            dip_d   = '0;
            sport_d = '0;
            dport_d = '0;
            vlan_d  = 1'b0;
        end else if (pop && (state_q == ST_HDR)) begin
            case (int'(off))
                OFF_ETYPE:        etype_d[15:8]  = byte_in;
                OFF_ETYPE + 1:    etype_d[7:0]   = byte_in;
                OFF_VIHL:         vihl_d         = byte_in;
                OFF_PROTO:        proto_d        = byte_in;
                OFF_SRC_IP:       sip_d[31:24]   = byte_in;
                OFF_SRC_IP + 1:   sip_d[23:16]   = byte_in;
                OFF_SRC_IP + 2:   sip_d[15:8]    = byte_in;
                OFF_SRC_IP + 3:   sip_d[7:0]     = byte_in;
                OFF_DST_IP:       dip_d[31:24]   = byte_in;
                OFF_DST_IP + 1:   dip_d[23:16]   = byte_in;
                OFF_DST_IP + 2:   dip_d[15:8]    = byte_in;
                OFF_DST_IP + 3:   dip_d[7:0]     = byte_in;
                OFF_SRC_PORT:     sport_d[15:8]  = byte_in;
                OFF_SRC_PORT + 1: sport_d[7:0]   = byte_in;
                OFF_DST_PORT:     dport_d[15:8]  = byte_in;
                OFF_DST_PORT + 1: dport_d[7:0]   = byte_in;
                default: ;
            endcase
`ifdef ACL_PARSE_VLAN_EN
            if ((int'(cnt_q) == OFF_ETYPE + 1) && ({etype_q[15:8], byte_in} == ETHERTYPE_VLAN)) begin
                vlan_d = 1'b1;
            end
`endif
        end
    end

    // The key is built from the next-state captures so byte 37 itself is included.
    always_comb begin
        ipv4     = (etype_d == ETHERTYPE_IPV4) && (vihl_d[7:4] == 4'd4);
        l4_valid = ipv4 && (vihl_d[3:0] == 4'd5) && is_l4_proto(proto_d);
        key_new          = '0;
        key_new.ipv4     = ipv4;
        key_new.l4_valid = l4_valid;
        key_new.runt     = key_runt;
        if (ipv4) begin
            key_new.src_ip = sip_d;
            key_new.dst_ip = dip_d;
            key_new.proto  = proto_d;
        end
        if (l4_valid) begin
            key_new.src_port = sport_d;
            key_new.dst_port = dport_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_load = 1'b0;
        key_runt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    if (i_fifo_last) begin
                        key_load = 1'b1;
                        key_runt = 1'b1;
                    end else begin
                        state_d = ST_HDR;
                        cnt_d   = CNT_WIDTH'(1);
                    end
                end
            end
            ST_HDR: begin
                if (pop) begin
                    if (int'(off) == OFF_HDR_END) begin
                        key_load = 1'b1;
                        state_d  = i_fifo_last ? ST_IDLE : ST_BODY;
                        cnt_d    = i_fifo_last ? '0 : cnt_inc;
                    end else if (i_fifo_last) begin
                        key_load = 1'b1;
                        key_runt = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_BODY: begin
                if (pop) begin
                    if (i_fifo_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            etype_q <= '0;
            vihl_q  <= '0;
            proto_q <= '0;
            sip_q   <= '0;
            dip_q   <= '0;
            sport_q <= '0;
            dport_q <= '0;
            vlan_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            etype_q <= etype_d;
            vihl_q  <= vihl_d;
            proto_q <= proto_d;
            sip_q   <= sip_d;
            dip_q   <= dip_d;
            sport_q <= sport_d;
            dport_q <= dport_d;
            vlan_q  <= vlan_d;
        end
    end

    acl_key_slot u_key_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (key_load),
        .key_i   (key_new),
        .ready_i (i_key_ready),
        .valid_o (o_key_valid),
        .key_o   (key_cur)
    );

    assign o_key_src_ip   = key_cur.src_ip;
    assign o_key_dst_ip   = key_cur.dst_ip;
    assign o_key_proto    = key_cur.proto;
    assign o_key_src_port = key_cur.src_port;
    assign o_key_dst_port = key_cur.dst_port;
    assign o_key_ipv4     = key_cur.ipv4;
    assign o_key_l4_valid = key_cur.l4_valid;
    assign o_key_runt     = key_cur.runt;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_acl_hdr_parser.sv
// Scoreboard bench for acl_hdr_parser: a FIFO model feeds random frames, a
// header-level reference model predicts the stream and keys, a monitor compares.
module tb_acl_hdr_parser;
    import acl_pkg::*;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic       sop;
        logic       ld;
        logic       last;
        logic [7:0] data;
    } ent_t;

`ifdef ACL_PARSE_VLAN_EN
    localparam bit VLAN_ON = 1'b1;
`else
    localparam bit VLAN_ON = 1'b0;
`endif

    logic        clk, rst;
    logic [7:0]  i_fifo_data;
    logic        i_fifo_last, i_fifo_empty, o_rd_valid;
    logic [7:0]  o_txd_tdata;
    logic        o_txd_tvalid, o_txd_tlast, i_txd_tready;
    logic        o_key_valid, i_key_ready;
    logic [31:0] o_key_src_ip, o_key_dst_ip;
    logic [7:0]  o_key_proto;
    logic [15:0] o_key_src_port, o_key_dst_port;
    logic        o_key_ipv4, o_key_l4_valid, o_key_runt;
    acl_state_e  o_dbg_state;

    ent_t       fifo_q[$];
    logic [8:0] exp_byte_q[$];
    acl_key_t   exp_key_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       rd_seen = 1'b0;
    logic       key_due = 1'b0;
    logic       rnd_empty = 1'b0;
    logic       rnd_tready = 1'b0;
    int         kr_mode = 0;

    acl_hdr_parser #(.DATA_WIDTH(8), .CNT_WIDTH(11)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_fifo_data    (i_fifo_data),
        .i_fifo_last    (i_fifo_last),
        .i_fifo_empty   (i_fifo_empty),
        .o_rd_valid     (o_rd_valid),
        .o_txd_tdata    (o_txd_tdata),
        .o_txd_tvalid   (o_txd_tvalid),
        .o_txd_tlast    (o_txd_tlast),
        .i_txd_tready   (i_txd_tready),
        .o_key_valid    (o_key_valid),
        .i_key_ready    (i_key_ready),
        .o_key_src_ip   (o_key_src_ip),
        .o_key_dst_ip   (o_key_dst_ip),
        .o_key_proto    (o_key_proto),
        .o_key_src_port (o_key_src_port),
        .o_key_dst_port (o_key_dst_port),
        .o_key_ipv4     (o_key_ipv4),
        .o_key_l4_valid (o_key_l4_valid),
        .o_key_runt     (o_key_runt),
        .o_dbg_state    (o_dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input logic ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model
    function automatic int hdr_shift(input bytes_t f);
        int s = 0;
        if (VLAN_ON && f.size() > 13 && f[12] == 8'h81 && f[13] == 8'h00) s = 4;
        return s;
    endfunction

    function automatic logic [7:0] gb(input bytes_t f, input int i);
        return (i < f.size()) ? f[i] : 8'h00;
    endfunction

    function automatic int load_index(input bytes_t f);
        int e = 37 + hdr_shift(f);
        return (f.size() <= e) ? f.size() - 1 : e;
    endfunction

    function automatic acl_key_t model_key(input bytes_t f);
        acl_key_t    k;
        int          s;
        logic [15:0] et;
        logic [7:0]  vi, pr;
        logic        v4, l4;
        s  = hdr_shift(f);
        et = {gb(f, 12 + s), gb(f, 13 + s)};
        vi = gb(f, 14 + s);
        pr = gb(f, 23 + s);
        v4 = (et == 16'h0800) && (vi[7:4] == 4'h4);
        l4 = v4 && (vi[3:0] == 4'h5) && (pr == 8'd6 || pr == 8'd17);
        k          = '0;
        k.runt     = (f.size() <= 37 + s);
        k.ipv4     = v4;
        k.l4_valid = l4;
        if (v4) begin
            k.src_ip = {gb(f, 26 + s), gb(f, 27 + s), gb(f, 28 + s), gb(f, 29 + s)};
            k.dst_ip = {gb(f, 30 + s), gb(f, 31 + s), gb(f, 32 + s), gb(f, 33 + s)};
            k.proto  = pr;
        end
        if (l4) begin
            k.src_port = {gb(f, 34 + s), gb(f, 35 + s)};
            k.dst_port = {gb(f, 36 + s), gb(f, 37 + s)};
        end
        return k;
    endfunction

    // driver tasks
    task automatic make_frame(input int kind, input int len, output bytes_t f);
        logic [7:0] t[96];
        int         s;
        for (int i = 0; i < 96; i++) t[i] = 8'($urandom_range(0, 255));
        s = (kind == 4) ? 4 : 0;
        if (kind == 4) begin
            t[12] = 8'h81;
            t[13] = 8'h00;
        end
        case (kind)
            0: begin
                t[12] = 8'h08; t[13] = 8'h00; t[14] = 8'h45; t[23] = 8'd6;
                t[26] = 8'd10;  t[27] = 8'd0;   t[28] = 8'd0; t[29] = 8'd1;
                t[30] = 8'd192; t[31] = 8'd168; t[32] = 8'd1; t[33] = 8'd2;
                t[34] = 8'h12; t[35] = 8'h34; t[36] = 8'h00; t[37] = 8'h50;
            end
            1: begin
                t[12] = 8'h08; t[13] = 8'h06;
            end
            2, 4: begin
                t[12 + s] = 8'h08; t[13 + s] = 8'h00; t[14 + s] = 8'h45;
                t[23 + s] = (kind == 2) ? 8'd17 : 8'd6;
            end
            3: begin
                t[12] = 8'h08; t[13] = 8'h00;
                t[14] = {($urandom_range(0, 3) == 0) ? 4'h6 : 4'h4, 4'($urandom_range(4, 6))};
                case ($urandom_range(0, 3))
                    0: t[23] = 8'd6;
                    1: t[23] = 8'd17;
                    2: t[23] = 8'd1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        f = {};
        for (int i = 0; i < len; i++) f.push_back(t[i]);
    endtask

    task automatic push_frame(input bytes_t f);
        ent_t e;
        int   ld = load_index(f);
        for (int i = 0; i < f.size(); i++) begin
            e.sop  = (i == 0);
            e.ld   = (i == ld);
            e.last = (i == f.size() - 1);
            e.data = f[i];
            fifo_q.push_back(e);
            exp_byte_q.push_back({e.last, e.data});
        end
        exp_key_q.push_back(model_key(f));
    endtask

    task automatic send(input int kind, input int len);
        bytes_t f;
        make_frame(kind, len, f);
        push_frame(f);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_byte_q.size() != 0 || exp_key_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(n < budget, name, 128'(exp_byte_q.size()), 128'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        logic [127:0] v;
        v = {o_rd_valid, o_txd_tdata, o_txd_tvalid, o_txd_tlast, o_key_valid,
             o_key_src_ip, o_key_dst_ip, o_key_proto, o_key_src_port, o_key_dst_port,
             o_key_ipv4, o_key_l4_valid, o_key_runt};
        chk(v == '0, name, v, 128'd0);
        chk(o_dbg_state == ST_IDLE, {name, "_state"}, 128'(o_dbg_state), 128'(ST_IDLE));
    endtask

    // FIFO model and handshake randomiser, updated just after each rising edge
    initial begin
        i_fifo_data  = 8'h00;
        i_fifo_last  = 1'b0;
        i_fifo_empty = 1'b1;
        i_txd_tready = 1'b1;
        i_key_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen && fifo_q.size() > 0) fifo_q.delete(0);
            i_fifo_empty = (fifo_q.size() == 0) || (rnd_empty && ($urandom_range(0, 1) == 1));
            if (fifo_q.size() > 0) begin
                i_fifo_data = fifo_q[0].data;
                i_fifo_last = fifo_q[0].last;
            end else begin
                i_fifo_data = 8'h00;
                i_fifo_last = 1'b0;
            end
            i_txd_tready = rnd_tready ? ($urandom_range(0, 1) == 1) : 1'b1;
            case (kr_mode)
                0:       i_key_ready = 1'b1;
                1:       i_key_ready = ($urandom_range(0, 1) == 1);
                default: i_key_ready = 1'b0;
            endcase
        end
    end

    // scoreboard monitor, sampling mid-cycle
    initial begin
        logic [8:0] exp_b;
        acl_key_t   act, exp_k;
        forever begin
            @(negedge clk);
            rd_seen = o_rd_valid;
            if (rst) begin
                if (key_due) begin
                    chk(o_key_valid == 1'b1, "key_latency", 128'(o_key_valid), 128'd1);
                    key_due = 1'b0;
                end
                if (o_txd_tvalid && i_txd_tready) begin
                    if (exp_byte_q.size() == 0) begin
                        chk(1'b0, "stream_extra", 128'({o_txd_tlast, o_txd_tdata}), 128'd0);
                    end else begin
                        exp_b = exp_byte_q.pop_front();
                        chk({o_txd_tlast, o_txd_tdata} == exp_b, "stream",
                            128'({o_txd_tlast, o_txd_tdata}), 128'(exp_b));
                    end
                    if (fifo_q.size() > 0 && fifo_q[0].ld) key_due = 1'b1;
                end
                if (!i_fifo_empty && fifo_q.size() > 0 && fifo_q[0].sop && o_key_valid && !i_key_ready) begin
                    chk(o_rd_valid == 1'b0, "stall", 128'(o_rd_valid), 128'd0);
                end
                if (o_key_valid && i_key_ready) begin
                    act.src_ip   = o_key_src_ip;
                    act.dst_ip   = o_key_dst_ip;
                    act.proto    = o_key_proto;
                    act.src_port = o_key_src_port;
                    act.dst_port = o_key_dst_port;
                    act.ipv4     = o_key_ipv4;
                    act.l4_valid = o_key_l4_valid;
                    act.runt     = o_key_runt;
                    if (exp_key_q.size() == 0) begin
                        chk(1'b0, "key_extra", 128'(act), 128'd0);
                    end else begin
                        exp_k = exp_key_q.pop_front();
                        chk(act == exp_k, "key", 128'(act), 128'(exp_k));
                    end
                end
            end
        end
    end

    // stimulus sequence and final report
    initial begin
        int n;
        int lens[6] = '{1, 2, 37, 38, 39, 15};
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #2 rst = 1'b1;

        send(0, 64);
        drain("tcp64_drain", 500);
        send(1, 60);
        drain("arp60_drain", 500);
        send(2, 20);
        send(0, 64);
        drain("runt20_drain", 500);

        kr_mode = 2;
        send(0, 64);
        send(2, 50);
        n = 0;
        while (exp_byte_q.size() > 50 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 1000, "b2b_first_frame", 128'(exp_byte_q.size()), 128'd50);
        repeat (20) @(negedge clk);
        chk(exp_byte_q.size() == 50, "b2b_held", 128'(exp_byte_q.size()), 128'd50);
        kr_mode = 0;
        drain("b2b_drain", 500);

        send(5, 1);
        send(4, 64);
        drain("single_vlan_drain", 500);

        rnd_empty  = 1'b1;
        rnd_tready = 1'b1;
        kr_mode    = 1;
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 5), (i < 6) ? lens[i] : $urandom_range(1, 90));
        end
        drain("random_drain", 40000);

        rnd_empty  = 1'b0;
        rnd_tready = 1'b0;
        kr_mode    = 0;
        send(0, 64);
        n = 0;
        while (exp_byte_q.size() > 39 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 1000, "pre_reset_progress", 128'(exp_byte_q.size()), 128'd39);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset_outputs");
        fifo_q.delete();
        exp_byte_q.delete();
        exp_key_q.delete();
        key_due = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        send(2, 64);
        drain("post_reset_udp_drain", 500);

        repeat (5) @(negedge clk);
        chk(fifo_q.size() == 0, "fifo_empty_end", 128'(fifo_q.size()), 128'd0);
        chk(o_key_valid == 1'b0, "no_key_left", 128'(o_key_valid), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
